// File: rtl/cpu_pkg.sv
// cpu_pkg: datapath sizing, ALU op codes and bus source indices shared by the
// datapath and the control-output module.
package cpu_pkg;
    localparam int WIDTH = 16;
    localparam int NREGS = 8;
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    // Bus source slots; a lower index wins when several drivers are active.
    localparam int SRC_DIN = 0;
    localparam int SRC_G   = 1;
    localparam int SRC_PC  = 2;
    localparam int SRC_R0  = 3;
    function automatic logic [1:0] alu_op(input logic addsub, input logic xorctrl);
        return xorctrl ? ALU_XOR : (addsub ? ALU_SUB : ALU_ADD);
    endfunction
endpackage

// File: rtl/cpu_reg.sv
// cpu_reg: load-enable register with asynchronous active-low clear.
module cpu_reg
    import cpu_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) q_o <= '0;
        else if (en_i) q_o <= d_i;
endmodule

// File: rtl/cpu_datapath.sv
// cpu_datapath: single-bus datapath (R0..R7, A, G, PC, IR) executing the
// per-cycle strobes issued by the control unit.
module cpu_datapath #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NREGS-1:0] rin,
    input  logic [NREGS-1:0] rout,
    input  logic             ain,
    input  logic             gin,
    input  logic             gout,
    input  logic             pcin,
    input  logic             pcincr,
    input  logic             pcout,
    input  logic             addsub,
    input  logic             xorctrl,
    input  logic             dinout,
    input  logic             irin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] g,
    output logic             bus_err
);
    import cpu_pkg::*;
    localparam int NSRC = SRC_R0 + NREGS;
    logic [WIDTH-1:0] r_q [NREGS];
    logic [WIDTH-1:0] src_val [NSRC];
    logic [NSRC-1:0]  drv;
    logic [WIDTH-1:0] bus_v, a_q, g_q, ir_q, pc_q, pc_d, alu;
    logic [1:0]       op;
    logic             err_q, err_d;
    assign drv = {rout, pcout, gout, dinout};
    // Scan from the weakest source up so the strongest active driver is written last.
    always_comb begin
        src_val[SRC_DIN] = din;
        src_val[SRC_G]   = g_q;
        src_val[SRC_PC]  = pc_q;
        for (int i = 0; i < NREGS; i++) src_val[SRC_R0+i] = r_q[i];
        bus_v = '0;
        for (int i = NSRC - 1; i >= 0; i--) if (drv[i]) bus_v = src_val[i];
    end
    assign op    = alu_op(addsub, xorctrl);
    assign alu   = op == ALU_XOR ? a_q ^ bus_v : op == ALU_SUB ? a_q - bus_v : a_q + bus_v;
    assign pc_d  = pcin ? bus_v : pcincr ? pc_q + WIDTH'(1) : pc_q;
    assign err_d = err_q | ($countones(drv) > 1);
    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        cpu_reg #(.W(WIDTH)) u_r (.clk(clk), .resetn(resetn), .en_i(rin[k]), .d_i(bus_v), .q_o(r_q[k]));
    end
    cpu_reg #(.W(WIDTH)) u_a  (.clk(clk), .resetn(resetn), .en_i(ain),  .d_i(bus_v), .q_o(a_q));
    cpu_reg #(.W(WIDTH)) u_g  (.clk(clk), .resetn(resetn), .en_i(gin),  .d_i(alu),   .q_o(g_q));
    cpu_reg #(.W(WIDTH)) u_ir (.clk(clk), .resetn(resetn), .en_i(irin), .d_i(din),   .q_o(ir_q));
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            pc_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    assign bus     = bus_v;
    assign ir      = ir_q;
    assign pc      = pc_q;
    assign g       = g_q;
    assign bus_err = err_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: directed and randomized strobe sequences scored against a
// behavioural model of the datapath; a negedge monitor drains the expectations.
module tb_cpu_datapath;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rin, rout;
    logic        ain, gin, gout, pcin, pcincr, pcout, addsub, xorctrl, dinout, irin;
    logic [15:0] din, bus, ir, pc, g;
    logic        bus_err;

    always #5 clk = ~clk;

    cpu_datapath #(.WIDTH(16), .NREGS(8)) dut (
        .clk(clk), .resetn(resetn), .rin(rin), .rout(rout), .ain(ain), .gin(gin), .gout(gout),
        .pcin(pcin), .pcincr(pcincr), .pcout(pcout), .addsub(addsub), .xorctrl(xorctrl),
        .dinout(dinout), .irin(irin), .din(din), .bus(bus), .ir(ir), .pc(pc), .g(g), .bus_err(bus_err)
    );

    typedef struct packed {
        logic [7:0]  rin, rout;
        logic        ain, gin, gout, pcin, pcincr, pcout, addsub, xorctrl, dinout, irin;
        logic [15:0] din;
    } stb_t;
    typedef struct packed {
        logic [15:0] bus, pc, g, ir;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0, fails = 0;
    logic [15:0] m_r[8];
    logic [15:0] m_a, m_g, m_pc, m_ir;
    logic        m_err;
    stb_t        s;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] m_bus(input stb_t t);
        if (t.dinout) return t.din;
        if (t.gout) return m_g;
        if (t.pcout) return m_pc;
        for (int k = 0; k < 8; k++) if (t.rout[k]) return m_r[k];
        return 16'h0000;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 8; k++) m_r[k] = 16'h0000;
        m_a = 0; m_g = 0; m_pc = 0; m_ir = 0; m_err = 0;
    endtask

    task automatic drive(input stb_t t);
        rin = t.rin; rout = t.rout; ain = t.ain; gin = t.gin; gout = t.gout; pcin = t.pcin;
        pcincr = t.pcincr; pcout = t.pcout; addsub = t.addsub; xorctrl = t.xorctrl;
        dinout = t.dinout; irin = t.irin; din = t.din;
    endtask

    // One clock cycle of strobes: outputs seen this cycle are the model's current
    // state plus the bus; the model then advances by one edge.
    task automatic cyc(input stb_t t);
        logic [15:0] b, res;
        @(posedge clk); #1;
        drive(t);
        b = m_bus(t);
        exp_q.push_back('{b, m_pc, m_g, m_ir, m_err});
        res = t.xorctrl ? (m_a ^ b) : t.addsub ? (m_a - b) : (m_a + b);
        for (int k = 0; k < 8; k++) if (t.rin[k]) m_r[k] = b;
        if (t.ain) m_a = b;
        if (t.gin) m_g = res;
        m_pc = t.pcin ? b : t.pcincr ? m_pc + 16'h1 : m_pc;
        if (t.irin) m_ir = t.din;
        if ($countones({t.dinout, t.gout, t.pcout, t.rout}) > 1) m_err = 1'b1;
    endtask

    task automatic hard_reset();
        drive('0);
        exp_q.delete();
        m_clear();
        resetn = 1'b0;
        #1;
        check("rst_pc", pc, 16'h0);
        check("rst_g", g, 16'h0);
        check("rst_ir", ir, 16'h0);
        check("rst_err", 16'(bus_err), 16'h0);
        resetn = 1'b1;
    endtask

    function automatic stb_t dv(input logic [15:0] d);
        stb_t t = '0;
        t.dinout = 1'b1;
        t.din = d;
        return t;
    endfunction

    function automatic stb_t add_drv(input stb_t t, input int n);
        stb_t u = t;
        if (n == 0) u.dinout = 1'b1;
        else if (n == 1) u.gout = 1'b1;
        else if (n == 2) u.pcout = 1'b1;
        else if (n <= 10) u.rout[n-3] = 1'b1;
        return u;
    endfunction

    function automatic stb_t rnd(input bit multi);
        stb_t t = '0;
        int   rsel;
        t.din = 16'($urandom);
        t = add_drv(t, $urandom_range(0, 11));
        if (multi && $urandom_range(0, 7) == 0) t = add_drv(t, $urandom_range(0, 10));
        rsel = $urandom_range(0, 3);
        t.rin = rsel == 0 ? 8'h00 : rsel == 3 ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
        t.ain = $urandom_range(0, 2) == 0;
        t.gin = $urandom_range(0, 2) == 0;
        t.pcin = $urandom_range(0, 5) == 0;
        t.pcincr = $urandom_range(0, 2) == 0;
        t.addsub = $urandom_range(0, 2) == 0;
        t.xorctrl = $urandom_range(0, 3) == 0;
        t.irin = $urandom_range(0, 3) == 0;
        return t;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bus", bus, e.bus);
            check("pc", pc, e.pc);
            check("g", g, e.g);
            check("ir", ir, e.ir);
            check("bus_err", 16'(bus_err), 16'(e.err));
        end
    end

    initial begin
        drive('0);
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        check("init_bus", bus, 16'h0);
        check("init_pc", pc, 16'h0);
        check("init_g", g, 16'h0);
        check("init_err", 16'(bus_err), 16'h0);
        resetn = 1'b1;
        // Populate state, then reset between edges
        s = dv(16'h1234); s.rin = 8'h08; cyc(s);
        s = dv(16'h0077); s.pcin = 1; s.irin = 1; s.gin = 1; cyc(s);
        cyc('0);
        hard_reset();
        s = '0; s.rout = 8'h08; cyc(s); #1; check("r3_after_reset", bus, 16'h0);
        // mv/add
        s = dv(16'h0005); s.rin = 8'h01; cyc(s);
        s = dv(16'h0003); s.rin = 8'h02; cyc(s);
        s = '0; s.rout = 8'h01; s.ain = 1; cyc(s);
        s = '0; s.rout = 8'h02; s.gin = 1; cyc(s);
        s = '0; s.gout = 1; s.rin = 8'h04; cyc(s);
        s = '0; s.rout = 8'h04; cyc(s); #1; check("add_r2", bus, 16'h0008);
        // Subtract wrap and XOR overriding addsub
        s = dv(16'h0000); s.ain = 1; cyc(s);
        s = dv(16'h0001); s.addsub = 1; s.gin = 1; cyc(s);
        cyc('0); check("sub_wrap", g, 16'hFFFF);
        s = dv(16'hFF00); s.ain = 1; cyc(s);
        s = dv(16'h0FF0); s.xorctrl = 1; s.addsub = 1; s.gin = 1; cyc(s);
        cyc('0); check("xor", g, 16'hF0F0);
        // PC wrap and pcin priority
        s = dv(16'hFFFF); s.pcin = 1; cyc(s);
        s = '0; s.pcincr = 1; cyc(s);
        cyc('0); check("pc_wrap", pc, 16'h0000);
        s = dv(16'h0040); s.pcin = 1; s.pcincr = 1; cyc(s);
        cyc('0); check("pcin_wins", pc, 16'h0040);
        // Broadcast write and self-reload
        s = dv(16'hBEEF); s.rin = 8'hFF; cyc(s);
        for (int k = 0; k < 8; k++) begin
            s = '0; s.rout = 8'(1 << k); cyc(s); #1; check($sformatf("bcast_r%0d", k), bus, 16'hBEEF);
        end
        s = '0; s.rout = 8'h10; s.rin = 8'h10; cyc(s); #1; check("self_load_bus", bus, 16'hBEEF);
        s = '0; s.rout = 8'h10; cyc(s); #1; check("self_load_r4", bus, 16'hBEEF);
        // G feeds back through the bus: FF00 + F0F0
        s = '0; s.gout = 1; s.gin = 1; cyc(s);
        cyc('0); check("gin_gout", g, 16'hEFF0);
        // Contention: G wins the bus, error is sticky until reset
        s = '0; s.rout = 8'h02; s.gout = 1; cyc(s); #1; check("contend_bus", bus, 16'hEFF0);
        cyc('0); check("err_set", 16'(bus_err), 16'h1);
        repeat (5) cyc('0);
        check("err_sticky", 16'(bus_err), 16'h1);
        hard_reset();
        repeat (400) cyc(rnd(1'b0));
        repeat (200) cyc(rnd(1'b1));
        cyc('0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
